// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, alignment check.
// Used by dmem_responder and dmem_lane_align; the optional counters are enabled by DMEM_PERF_COUNT_EN.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // funct3[1:0] carries the access size; any code other than byte/half is treated as a word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the EX/MEM stage and the data-memory responder.
// The pipeline side uses the master modport and the responder uses the slave modport.
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Ready;
    logic        Stall;
    logic        MisalignErr;

    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, Ready, Stall, MisalignErr
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, Ready, Stall, MisalignErr
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables/lane replication and
// load lane extraction with sign or zero extension. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_rd_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wr_lanes,
    output logic [31:0] o_rd_data
);

    logic       w_misaligned;
    logic       w_signed;
    logic [7:0] w_bytes [4];
    logic [7:0] w_byte_sel;
    logic [15:0] w_half_sel;

    assign w_misaligned = is_misaligned(i_funct3, i_addr_lo);
    assign w_signed     = ~i_funct3[2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = i_rd_word[8*gi +: 8];
        end
    endgenerate

    assign w_byte_sel = w_bytes[i_addr_lo];
    assign w_half_sel = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    always_comb begin
        o_byte_en  = 4'b0000;
        o_wr_lanes = i_wr_data;
        o_rd_data  = i_rd_word;
        case (i_funct3[1:0])
            2'b00: begin
                o_byte_en  = 4'b0001 << i_addr_lo;
                o_wr_lanes = {4{i_wr_data[7:0]}};
                o_rd_data  = {{24{w_signed & w_byte_sel[7]}}, w_byte_sel};
            end
            2'b01: begin
                o_byte_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wr_lanes = {2{i_wr_data[15:0]}};
                o_rd_data  = {{16{w_signed & w_half_sel[15]}}, w_half_sel};
            end
            default: begin
                o_byte_en  = 4'b1111;
                o_wr_lanes = i_wr_data;
                o_rd_data  = i_rd_word;
            end
        endcase
        // A misaligned access neither writes nor returns data.
        if (w_misaligned) begin
            o_byte_en = 4'b0000;
            o_rd_data = 32'd0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, stalls for WAIT_CYCLES, then pulses Ready.
// Define DMEM_PERF_COUNT_EN to add LoadCount/StoreCount/StallCycles outputs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
`ifdef DMEM_PERF_COUNT_EN
    ,
    output logic [31:0]       LoadCount,
    output logic [31:0]       StoreCount,
    output logic [31:0]       StallCycles
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [31:0]       r_rd_word;

    dmem_state_t       r_state;
    dmem_state_t       w_state_next;
    logic [3:0]        r_wait_cnt;
    logic [IDX_W+1:0]  r_addr;
    logic [31:0]       r_wr_data;
    logic [2:0]        r_funct3;
    logic              r_is_store;
    logic              r_misalign;

    logic              w_req;
    logic              w_accept;
    logic              w_complete;
    logic              w_stall;
    logic [IDX_W+1:0]  w_op_addr;
    logic [IDX_W-1:0]  w_op_idx;
    logic [31:0]       w_op_wr_data;
    logic [2:0]        w_op_funct3;
    logic              w_op_store;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_wr_lanes;
    logic [31:0]       w_rd_ext;

    // Reset gates the request so Stall drops and nothing commits while reset is held.
    assign w_req    = ~reset & (bus.MemRead | bus.MemWrite);
    assign w_accept = (r_state == IDLE) & w_req;
    assign w_complete = ((r_state == IDLE) & w_req & (WAIT_CYCLES == 0)) |
                        ((r_state == WAIT) & (r_wait_cnt == 4'd0));

    // With zero wait states the access completes on the accepting edge, so the live inputs stand in for the latches.
    always_comb begin
        w_op_addr    = r_addr;
        w_op_wr_data = r_wr_data;
        w_op_funct3  = r_funct3;
        w_op_store   = r_is_store;
        if (r_state == IDLE) begin
            w_op_addr    = bus.Addr[IDX_W+1:0];
            w_op_wr_data = bus.WrData;
            w_op_funct3  = bus.Funct3;
            w_op_store   = bus.MemWrite;
        end
    end

    assign w_op_idx = w_op_addr[IDX_W+1:2];

    dmem_lane_align u_lane_align (
        .i_funct3   (w_op_funct3),
        .i_addr_lo  (w_op_addr[1:0]),
        .i_wr_data  (w_op_wr_data),
        .i_rd_word  (r_rd_word),
        .o_byte_en  (w_byte_en),
        .o_wr_lanes (w_wr_lanes),
        .o_rd_data  (w_rd_ext)
    );

    always_ff @(posedge clk) begin
        if (w_complete) begin
            if (w_op_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_byte_en[b]) begin
                        r_mem[w_op_idx][8*b +: 8] <= w_wr_lanes[8*b +: 8];
                    end
                end
            end else begin
                r_rd_word <= r_mem[w_op_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_wr_data  <= 32'd0;
            r_funct3   <= 3'd0;
            r_is_store <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr     <= bus.Addr[IDX_W+1:0];
                r_wr_data  <= bus.WrData;
                r_funct3   <= bus.Funct3;
                r_is_store <= bus.MemWrite;
                r_wait_cnt <= WAIT_INIT;
            end else if ((r_state == WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_complete) begin
                r_misalign <= is_misaligned(w_op_funct3, w_op_addr[1:0]);
            end else if (r_state == DONE) begin
                r_misalign <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_stall         = 1'b0;
        bus.Ready       = 1'b0;
        bus.RdData      = 32'd0;
        bus.MisalignErr = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_req;
                if (w_req) begin
                    w_state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                w_stall = ~reset;
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.Ready       = 1'b1;
                bus.RdData      = w_rd_ext;
                bus.MisalignErr = r_misalign;
                w_state_next    = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        bus.Stall = w_stall;
    end

`ifdef DMEM_PERF_COUNT_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_cnt  <= 32'd0;
            r_store_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (r_state == DONE) begin
                if (r_is_store) r_store_cnt <= r_store_cnt + 32'd1;
                else            r_load_cnt  <= r_load_cnt + 32'd1;
            end
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign LoadCount   = r_load_cnt;
    assign StoreCount  = r_store_cnt;
    assign StallCycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array reference model.
// Covers DMEM_PERF_COUNT_EN counters when the macro is defined.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 128;
    localparam int WC    = 2;
    localparam int NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

`ifdef DMEM_PERF_COUNT_EN
    logic [31:0] load_cnt, store_cnt, stall_cnt;
    logic [31:0] load_cnt0, store_cnt0, stall_cnt0;
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_PERF_COUNT_EN
        ,
        .LoadCount   (load_cnt),
        .StoreCount  (store_cnt),
        .StallCycles (stall_cnt)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
`ifdef DMEM_PERF_COUNT_EN
        ,
        .LoadCount   (load_cnt0),
        .StoreCount  (store_cnt0),
        .StallCycles (stall_cnt0)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  model_bytes [NBYTES];
    logic [31:0] last_rd;
    logic        last_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz = acc_size(f3);
        int base = int'(addr % NBYTES);
        logic [31:0] v = 32'd0;
        if (model_mis(f3, addr)) return 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(model_bytes[base + k]) << (8 * k));
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        int sz = acc_size(f3);
        int base = int'(addr % NBYTES);
        if (model_mis(f3, addr)) return;
        for (int k = 0; k < sz; k++) model_bytes[base + k] = data[8*k +: 8];
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data);
        int cyc;
        bit got;
        bit exp_mis;
        logic [31:0] exp_rd;
        exp_mis = model_mis(f3, addr);
        exp_rd  = model_load(f3, addr);
        @(negedge clk);
        bus.MemRead = rd; bus.MemWrite = wr; bus.Funct3 = f3; bus.Addr = addr; bus.WrData = data;
        #1;
        check("stall_req", 32'(bus.Stall), 32'd1);
        got = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.Ready) begin got = 1; break; end
            check("stall_wait", 32'(bus.Stall), 32'd1);
        end
        check("ready_cycle", 32'(cyc), 32'(WC + 1));
        last_rd  = bus.RdData;
        last_mis = bus.MisalignErr;
        if (got) begin
            check("stall_done", 32'(bus.Stall), 32'd0);
            check("misalign", 32'(bus.MisalignErr), 32'(exp_mis));
            if (!wr) check("rddata", bus.RdData, exp_rd);
        end
        if (wr) model_store(f3, addr, data);
        $display("txn %s f3=%0d addr=%h wdata=%h rdata=%h mis=%0d cyc=%0d",
                 wr ? "ST" : "LD", f3, addr, data, bus.RdData, bus.MisalignErr, cyc);
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse", 32'(bus.Ready), 32'd0);
    endtask

    task automatic access0(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_rd);
        int cyc;
        @(negedge clk);
        bus0.MemRead = ~wr; bus0.MemWrite = wr; bus0.Funct3 = f3; bus0.Addr = addr; bus0.WrData = data;
        #1;
        check("w0_stall_req", 32'(bus0.Stall), 32'd1);
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (bus0.Ready) break;
        end
        check("w0_ready_cycle", 32'(cyc), 32'd1);
        if (!wr) check("w0_rddata", bus0.RdData, exp_rd);
        $display("txn W0 %s addr=%h wdata=%h rdata=%h cyc=%0d", wr ? "ST" : "LD", addr, data, bus0.RdData, cyc);
        bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  st_codes [6];
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          is_wr;
        st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < NBYTES; i++) model_bytes[i] = 8'h00;

        reset = 1'b1;
        bus.MemRead = 0; bus.MemWrite = 0; bus.Funct3 = 0; bus.Addr = 0; bus.WrData = 0;
        bus0.MemRead = 0; bus0.MemWrite = 0; bus0.Funct3 = 0; bus0.Addr = 0; bus0.WrData = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_rddata", bus.RdData, 32'd0);
        check("rst_misalign", 32'(bus.MisalignErr), 32'd0);
        check("rst_stall", 32'(bus.Stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int w = 0; w < DEPTH; w++) do_access(1'b0, 1'b1, F3_W, 32'(w * 4), $urandom);

        do_access(0, 1, F3_W, 32'h10, 32'hDEADBEEF);
        do_access(1, 0, F3_W, 32'h10, 32'h0);
        check("lw_deadbeef", last_rd, 32'hDEADBEEF);
        do_access(0, 1, F3_W, 32'h10, 32'h11223344);
        do_access(0, 1, F3_B, 32'h13, 32'h000000AA);
        do_access(1, 0, F3_B, 32'h13, 32'h0);
        check("lb_sext", last_rd, 32'hFFFFFFAA);
        do_access(1, 0, F3_BU, 32'h13, 32'h0);
        check("lbu_zext", last_rd, 32'h000000AA);
        do_access(1, 0, F3_W, 32'h10, 32'h0);
        check("lw_after_sb", last_rd, 32'hAA223344);
        do_access(0, 1, F3_W, 32'h20, 32'h0);
        do_access(0, 1, F3_H, 32'h22, 32'h00008001);
        do_access(1, 0, F3_H, 32'h22, 32'h0);
        check("lh_sext", last_rd, 32'hFFFF8001);
        do_access(1, 0, F3_HU, 32'h22, 32'h0);
        check("lhu_zext", last_rd, 32'h00008001);
        do_access(1, 0, F3_W, 32'h05, 32'h0);
        check("lw_mis_flag", 32'(last_mis), 32'd1);
        check("lw_mis_data", last_rd, 32'd0);
        do_access(0, 1, F3_W, 32'h06, 32'hFFFFFFFF);
        do_access(1, 0, F3_W, 32'h04, 32'h0);

        for (int n = 0; n < 80; n++) begin
            is_wr = $urandom_range(0, 1);
            f3 = is_wr ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(acc_size(f3) - 1);
            do_access(~is_wr | ($urandom_range(0, 3) == 0), is_wr, f3, addr, $urandom);
        end

        // Reset in the middle of a store must drop it.
        do_access(0, 1, F3_W, 32'h30, 32'h0);
        @(negedge clk);
        bus.MemWrite = 1; bus.MemRead = 0; bus.Funct3 = F3_W; bus.Addr = 32'h30; bus.WrData = 32'h12345678;
        @(posedge clk); #1;
        check("mid_stall", 32'(bus.Stall), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_stall", 32'(bus.Stall), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_no_ready", 32'(bus.Ready), 32'd0);
        end
        @(negedge clk);
        bus.MemWrite = 0;
        reset = 1'b0;
`ifdef DMEM_PERF_COUNT_EN
        #1;
        check("perf_rst_load", load_cnt, 32'd0);
        check("perf_rst_store", store_cnt, 32'd0);
        check("perf_rst_stall", stall_cnt, 32'd0);
`endif
        do_access(1, 0, F3_W, 32'h30, 32'h0);
        check("dropped_store", last_rd, 32'h0);
        do_access(1, 1, F3_W, 32'h40, 32'h5);
        do_access(1, 0, F3_W, 32'h40, 32'h0);
        check("both_store_wins", last_rd, 32'h5);
        do_access(0, 1, F3_W, 32'h44, 32'h0BADF00D);
        do_access(1, 0, F3_W, 32'h44, 32'h0);
`ifdef DMEM_PERF_COUNT_EN
        check("perf_load", load_cnt, 32'd3);
        check("perf_store", store_cnt, 32'd2);
        check("perf_stall", stall_cnt, 32'd15);
`endif

        access0(1'b1, F3_W, 32'h8, 32'hCAFEF00D, 32'h0);
        access0(1'b0, F3_W, 32'h8, 32'h0, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
